bbox_tracker: RTL
=================

Name: bbox_tracker

Overview:
Parametrised successor to the fixed six-colour bounding-box logic in the image-processing pipeline. It consumes the per-pixel colour-class flags and the Avalon-ST beat controls, and accumulates a bounding box and a pixel count per channel inside a programmable region of interest (ROI). At each video end-of-packet it latches the results. Every MSG_INTERVAL video frames it serialises them as 32-bit words on a valid/ready message port that feeds the message FIFO.

Parameters:
N_CH, 6, number of colour channels (1..15)
CW, 11, coordinate width (CW <= 16)
CNTW, 20, per-channel pixel-count width (CNTW <= 32)
IMAGE_W, 640, pixels per line
IMAGE_H, 480, lines per frame
MSG_INTERVAL, 32, video frames between reports (>= 1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
pix_valid  in  1  beat accepted this cycle
pix_sop  in  1  start of packet (header beat, not a pixel)
pix_eop  in  1  end of packet (last pixel)
pix_video  in  1  sampled with sop: 1 = video packet
class_hit  in  N_CH  per-channel colour match for this pixel
roi_x_lo, roi_x_hi, roi_y_lo, roi_y_hi  in  CW each  inclusive ROI bounds
min_count  in  CNTW  minimum pixel count for a box to be valid
box_valid  out  N_CH  latched per-channel validity
frame_done  out  1  one-cycle pulse when results are latched
msg_data  out  32  message word
msg_valid  out  1  message word available
msg_ready  in  1  sink accepts the word
drop_cnt  out  8  reports skipped because the emitter was busy (saturating)

Behaviour:
- Reset clears every output to 0 and drops the in_frame flag. Emitter goes to IDLE. frame_cnt = 0, so the first video frame reports.
- Beat with pix_valid & pix_sop: x = y = 0, packet_video <= pix_video, in_frame <= 1, all accumulators cleared (x_min = y_min = all-ones, x_max = y_max = 0, count = 0). An sop arriving mid-frame discards the partial frame.
- Pixel beat (pix_valid & ~pix_sop & in_frame): x increments; at IMAGE_W-1 it wraps to 0 and y increments. Beats received before the first sop are ignored.
- Accumulation applies only when packet_video is set and roi_x_lo <= x <= roi_x_hi and roi_y_lo <= y <= roi_y_hi. The lowest-index set bit of class_hit wins; other set bits are ignored. The winning channel updates its min/max, and its count saturates at 2^CNTW-1.
- Eop pixel beat is accumulated first. On the next cycle the results latch, box_valid[i] = (count[i] >= min_count), frame_done pulses, and in_frame clears. A non-video eop only clears in_frame.
- Frame scheduling on each video frame_done:
  - If frame_cnt == 0 and the emitter is IDLE: snapshot all results into shadow registers, reload frame_cnt = MSG_INTERVAL-1, enter EMIT.
  - If frame_cnt == 0 and the emitter is busy: increment drop_cnt (saturates at 255) and keep frame_cnt = 0.
  - Otherwise decrement frame_cnt.
- Emitter FSM states: IDLE, HDR, CH_X, CH_Y, CH_N, then back through CH_X for the next channel, and IDLE after the last CH_N.
  - HDR word = {8'hA5, 4'(N_CH), 4'h0, 16'(frame_seq)}. frame_seq increments per report and wraps.
  - CH_X = {16'(x_min), 16'(x_max)}; CH_Y = {16'(y_min), 16'(y_max)}; CH_N = 32'(count). Each field is zero-extended.
  - An invalid channel reports zeros in CH_X/CH_Y and its true count in CH_N.
  - A report is 1 + 3*N_CH words.
- Handshake: msg_valid is registered. msg_data is held stable while msg_valid & ~msg_ready. A word transfers when msg_valid & msg_ready, and the next word can follow on the next cycle, giving back-to-back throughput.
- Latency: eop beat to frame_done is 1 cycle. frame_done to first msg_valid is 1 cycle.
- Reset mid-report truncates the report; no partial word is re-sent.

Optional Feature:
- Macro: BBOX_OVERLAY_EN.
- Defined: adds output bb_edge[N_CH-1:0], combinational from the current x,y and the latched boxes. A bit is high on a box's perimeter for valid boxes only, matching the drawing logic in the existing overlay.
- Undefined: the port is absent and no comparators are generated.

Decomposition:
- Package bbox_pkg: the header constant 8'hA5, the emitter state enum, and a typedef struct box_t {x_min, x_max, y_min, y_max, count}, with widths taken from package parameters.
- Sub-module bbox_emit: the shadow registers, the FSM and the valid/ready output stage.
- Accumulators and the coordinate counter stay in the top level.

Test Plan:
1. N_CH=2, 8x4 image, ROI full frame, channel 0 hit at (2,1) and (5,3), min_count=1 -> frame_done 1 cycle after eop. Report words: A5_2_0_0000, 0002_0005, 0001_0003, 00000002, then zeros/0 for channel 1.
2. class_hit=2'b11 on every pixel -> only channel 0 counts (32); channel 1 count 0, box_valid=2'b01.
3. ROI x 3..4, hits everywhere -> x_min=3, x_max=4. min_count=9 with 8 hits -> box_valid[0]=0, CH_X/CH_Y zero, CH_N=8.
4. MSG_INTERVAL=2, msg_ready held 0 across three frames -> first report stalls at HDR with stable data. drop_cnt=1 after frame 3; frame_seq continues at 1 when released.
5. msg_ready toggling 1,0,1 -> no word duplicated or lost; 1+3*N_CH transfers total.
6. Non-video packet, then pixels without sop, then reset_n low mid-report -> no accumulation or report from those beats. After reset all outputs 0, and the next video frame reports with frame_seq 0.

Source files
------------

// File: rtl/bbox_pkg.sv
// bbox_pkg: shared definitions for the bounding-box tracker slice.
//   HDR_TAG      - marker byte leading every report header word
//   BOX_CW       - field width of one coordinate inside a report word
//   BOX_CNTW     - field width of one pixel count inside a report word
//   emit_state_e - report emitter states
//   box_t        - one channel's box and count, zero-extended to report widths
package bbox_pkg;

  localparam logic [7:0] HDR_TAG  = 8'hA5;
  localparam int         BOX_CW   = 16;
  localparam int         BOX_CNTW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CH_X,
    ST_CH_Y,
    ST_CH_N
  } emit_state_e;

  typedef struct packed {
    logic [BOX_CW-1:0]   x_min;
    logic [BOX_CW-1:0]   x_max;
    logic [BOX_CW-1:0]   y_min;
    logic [BOX_CW-1:0]   y_max;
    logic [BOX_CNTW-1:0] count;
  } box_t;

endpackage

// File: rtl/bbox_emit.sv
// bbox_emit: frame scheduling, result snapshot and report serialiser.
// Every MSG_INTERVAL video frames the latched boxes are copied into shadow
// registers and sent as 1 + 3*N_CH words over a registered valid/ready port.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   frame_done_i           video frame results are ready this cycle
//   boxes_i, valid_i       per-channel results and validity to snapshot
//   msg_data_o/valid_o     report word stream, msg_ready_i accepts a word
//   drop_cnt_o             reports skipped while a report was in flight
module bbox_emit
  import bbox_pkg::*;
#(
  parameter int N_CH         = 6,
  parameter int MSG_INTERVAL = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_done_i,
  input  box_t [N_CH-1:0]       boxes_i,
  input  logic [N_CH-1:0]       valid_i,
  output logic [31:0]           msg_data_o,
  output logic                  msg_valid_o,
  input  logic                  msg_ready_i,
  output logic [7:0]            drop_cnt_o
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FCW = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;

  emit_state_e     state_q, state_d;
  logic [CHW-1:0]  chIdx_q, chIdx_d, nextCh;
  logic [15:0]     frameSeq_q, frameSeq_d;
  logic [FCW-1:0]  frameCnt_q, frameCnt_d;
  logic [7:0]      dropCnt_q, dropCnt_d;
  logic [31:0]     msgData_q, msgData_d;
  logic            msgValid_q, msgValid_d;
  box_t [N_CH-1:0] shadow_q;
  logic [N_CH-1:0] shadowValid_q;
  logic            start, take;

  // Invalid channels hide their coordinates but still report their count.
  function automatic logic [31:0] chWord(emit_state_e kind, box_t b, logic vld);
    logic [31:0] w;
    w = b.count;
    if (kind == ST_CH_X) w = vld ? {b.x_min, b.x_max} : '0;
    else if (kind == ST_CH_Y) w = vld ? {b.y_min, b.y_max} : '0;
    return w;
  endfunction

  // Scheduling decides whether a finished frame starts a report or is
  // dropped; the FSM then walks header and per-channel words, advancing
  // only when the current word has been taken by the sink.
  always_comb begin
    state_d    = state_q;
    chIdx_d    = chIdx_q;
    frameSeq_d = frameSeq_q;
    frameCnt_d = frameCnt_q;
    dropCnt_d  = dropCnt_q;
    msgData_d  = msgData_q;
    msgValid_d = msgValid_q;
    start      = 1'b0;
    take       = msgValid_q & msg_ready_i;
    nextCh     = chIdx_q + CHW'(1);

    if (frame_done_i) begin
      if (frameCnt_q == '0) begin
        if (state_q == ST_IDLE) begin
          start      = 1'b1;
          frameCnt_d = FCW'(MSG_INTERVAL - 1);
        end else if (dropCnt_q != 8'hFF) begin
          dropCnt_d = dropCnt_q + 8'd1;
        end
      end else begin
        frameCnt_d = frameCnt_q - FCW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msgData_d  = {HDR_TAG, 4'(N_CH), 4'h0, frameSeq_q};
          msgValid_d = 1'b1;
          frameSeq_d = frameSeq_q + 16'd1;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (take) begin
          chIdx_d   = '0;
          msgData_d = chWord(ST_CH_X, shadow_q[0], shadowValid_q[0]);
          state_d   = ST_CH_X;
        end
      end
      ST_CH_X: begin
        if (take) begin
          msgData_d = chWord(ST_CH_Y, shadow_q[chIdx_q], shadowValid_q[chIdx_q]);
          state_d   = ST_CH_Y;
        end
      end
      ST_CH_Y: begin
        if (take) begin
          msgData_d = chWord(ST_CH_N, shadow_q[chIdx_q], shadowValid_q[chIdx_q]);
          state_d   = ST_CH_N;
        end
      end
      ST_CH_N: begin
        if (take) begin
          if (chIdx_q == CHW'(N_CH - 1)) begin
            msgData_d  = '0;
            msgValid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            chIdx_d   = nextCh;
            msgData_d = chWord(ST_CH_X, shadow_q[nextCh], shadowValid_q[nextCh]);
            state_d   = ST_CH_X;
          end
        end
      end
      default: begin
        msgValid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, output stage and shadow copy; the shadow is only loaded when a
  // report starts so later frames cannot disturb a report in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      chIdx_q       <= '0;
      frameSeq_q    <= '0;
      frameCnt_q    <= '0;
      dropCnt_q     <= '0;
      msgData_q     <= '0;
      msgValid_q    <= 1'b0;
      shadow_q      <= '0;
      shadowValid_q <= '0;
    end else begin
      state_q    <= state_d;
      chIdx_q    <= chIdx_d;
      frameSeq_q <= frameSeq_d;
      frameCnt_q <= frameCnt_d;
      dropCnt_q  <= dropCnt_d;
      msgData_q  <= msgData_d;
      msgValid_q <= msgValid_d;
      if (start) begin
        shadow_q      <= boxes_i;
        shadowValid_q <= valid_i;
      end
    end
  end

  assign msg_data_o  = msgData_q;
  assign msg_valid_o = msgValid_q;
  assign drop_cnt_o  = dropCnt_q;

endmodule

// File: rtl/bbox_tracker.sv
// bbox_tracker: per-channel bounding box and pixel count inside a
// programmable ROI, latched at each video end-of-packet and reported
// periodically through bbox_emit.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   pix_valid/sop/eop/video       Avalon-ST beat controls
//   class_hit                     per-channel colour match of this pixel
//   roi_x_lo/hi, roi_y_lo/hi      inclusive region of interest
//   min_count                     count threshold for a valid box
//   box_valid, frame_done         latched validity, one-cycle latch pulse
//   msg_data/valid/ready          report word stream
//   drop_cnt                      saturating count of skipped reports
//   bb_edge                       box perimeter flags (BBOX_OVERLAY_EN only)
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int N_CH         = 6,
  parameter int CW           = 11,
  parameter int CNTW         = 20,
  parameter int IMAGE_W      = 640,
  parameter int IMAGE_H      = 480,
  parameter int MSG_INTERVAL = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pix_valid,
  input  logic            pix_sop,
  input  logic            pix_eop,
  input  logic            pix_video,
  input  logic [N_CH-1:0] class_hit,
  input  logic [CW-1:0]   roi_x_lo,
  input  logic [CW-1:0]   roi_x_hi,
  input  logic [CW-1:0]   roi_y_lo,
  input  logic [CW-1:0]   roi_y_hi,
  input  logic [CNTW-1:0] min_count,
  output logic [N_CH-1:0] box_valid,
  output logic            frame_done,
  output logic [31:0]     msg_data,
  output logic            msg_valid,
  input  logic            msg_ready,
  output logic [7:0]      drop_cnt
`ifdef BBOX_OVERLAY_EN
  ,output logic [N_CH-1:0] bb_edge
`endif
);

  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic            inFrame_q, inFrame_d, video_q, video_d;
  logic [CW-1:0]   xMin_q [N_CH], xMin_d [N_CH], xMax_q [N_CH], xMax_d [N_CH];
  logic [CW-1:0]   yMin_q [N_CH], yMin_d [N_CH], yMax_q [N_CH], yMax_d [N_CH];
  logic [CNTW-1:0] cnt_q [N_CH], cnt_d [N_CH];
  logic [N_CH-1:0] boxValid_q, boxValid_d, winner;
  logic            frameDone_q, frameDone_d, pixBeat, inRoi;
  box_t [N_CH-1:0] boxes;

  // Beat decoding, coordinate tracking and accumulation. Only the
  // lowest-index matching channel is credited with a pixel; results are
  // judged against min_count using the post-update counts so the eop pixel
  // is included.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    inFrame_d   = inFrame_q;
    video_d     = video_q;
    xMin_d      = xMin_q;
    xMax_d      = xMax_q;
    yMin_d      = yMin_q;
    yMax_d      = yMax_q;
    cnt_d       = cnt_q;
    boxValid_d  = boxValid_q;
    frameDone_d = 1'b0;
    pixBeat     = pix_valid & ~pix_sop & inFrame_q;
    inRoi       = (x_q >= roi_x_lo) && (x_q <= roi_x_hi) &&
                  (y_q >= roi_y_lo) && (y_q <= roi_y_hi);
    winner      = class_hit & (~class_hit + N_CH'(1));

    if (pix_valid && pix_sop) begin
      x_d       = '0;
      y_d       = '0;
      video_d   = pix_video;
      inFrame_d = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        xMin_d[i] = '1;
        yMin_d[i] = '1;
        xMax_d[i] = '0;
        yMax_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end else if (pixBeat) begin
      if (video_q && inRoi) begin
        for (int i = 0; i < N_CH; i++) begin
          if (winner[i]) begin
            if (x_q < xMin_q[i]) xMin_d[i] = x_q;
            if (x_q > xMax_q[i]) xMax_d[i] = x_q;
            if (y_q < yMin_q[i]) yMin_d[i] = y_q;
            if (y_q > yMax_q[i]) yMax_d[i] = y_q;
            if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNTW'(1);
          end
        end
      end
      // y also wraps so an oversized packet cannot walk past the image.
      if (x_q == CW'(IMAGE_W - 1)) begin
        x_d = '0;
        y_d = (y_q == CW'(IMAGE_H - 1)) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
      if (pix_eop) begin
        inFrame_d = 1'b0;
        if (video_q) begin
          frameDone_d = 1'b1;
          for (int i = 0; i < N_CH; i++) boxValid_d[i] = (cnt_d[i] >= min_count);
        end
      end
    end
  end

  // Frame-level registers; accumulators start empty out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      inFrame_q   <= 1'b0;
      video_q     <= 1'b0;
      boxValid_q  <= '0;
      frameDone_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        xMin_q[i] <= '1;
        yMin_q[i] <= '1;
        xMax_q[i] <= '0;
        yMax_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      inFrame_q   <= inFrame_d;
      video_q     <= video_d;
      boxValid_q  <= boxValid_d;
      frameDone_q <= frameDone_d;
      xMin_q      <= xMin_d;
      xMax_q      <= xMax_d;
      yMin_q      <= yMin_d;
      yMax_q      <= yMax_d;
      cnt_q       <= cnt_d;
    end
  end

  // While frame_done is high the accumulators hold the final frame values,
  // which is exactly when the emitter may snapshot them.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      boxes[i].x_min = BOX_CW'(xMin_q[i]);
      boxes[i].x_max = BOX_CW'(xMax_q[i]);
      boxes[i].y_min = BOX_CW'(yMin_q[i]);
      boxes[i].y_max = BOX_CW'(yMax_q[i]);
      boxes[i].count = BOX_CNTW'(cnt_q[i]);
    end
  end

  bbox_emit #(
    .N_CH         (N_CH),
    .MSG_INTERVAL (MSG_INTERVAL)
  ) u_emit (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .frame_done_i (frameDone_q),
    .boxes_i      (boxes),
    .valid_i      (boxValid_q),
    .msg_data_o   (msg_data),
    .msg_valid_o  (msg_valid),
    .msg_ready_i  (msg_ready),
    .drop_cnt_o   (drop_cnt)
  );

  assign box_valid  = boxValid_q;
  assign frame_done = frameDone_q;

`ifdef BBOX_OVERLAY_EN
  logic [CW-1:0] ovXMin_q [N_CH], ovXMax_q [N_CH], ovYMin_q [N_CH], ovYMax_q [N_CH];

  // Boxes drawn on the following frame come from the last latched result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        ovXMin_q[i] <= '0;
        ovXMax_q[i] <= '0;
        ovYMin_q[i] <= '0;
        ovYMax_q[i] <= '0;
      end
    end else if (frameDone_d) begin
      ovXMin_q <= xMin_d;
      ovXMax_q <= xMax_d;
      ovYMin_q <= yMin_d;
      ovYMax_q <= yMax_d;
    end
  end

  // A pixel is on the perimeter when it lies on an edge column within the
  // box's rows, or on an edge row within its columns.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      bb_edge[i] = boxValid_q[i] &&
        ((((x_q == ovXMin_q[i]) || (x_q == ovXMax_q[i])) &&
          (y_q >= ovYMin_q[i]) && (y_q <= ovYMax_q[i])) ||
         (((y_q == ovYMin_q[i]) || (y_q == ovYMax_q[i])) &&
          (x_q >= ovXMin_q[i]) && (x_q <= ovXMax_q[i])));
    end
  end
`endif

endmodule
